main_alu_pipe: RTL

MAIN_ALU_PIPE -- requirements
Module: main_alu_pipe

---
 rtl/main_alu_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/main_alu_pipe.sv
// Pipelined ALU: single-cycle arithmetic/logic ops plus an iterative signed
// multiplier that occupies the block for WIDTH cycles per product.
module main_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           alu_control,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow,
    output logic                 zero,
    output logic                 dbg_state_o
);
    // Handshake: an operation is taken on a rising edge where in_valid and
    // in_ready are both high; in_valid without in_ready is simply dropped.
    localparam int W2  = 2 * WIDTH;
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q;
    logic [W2-1:0]     mcand_q;
    logic [W2-1:0]     acc_q;
    logic [WIDTH-1:0]  mplier_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [W2-1:0]     result_q;
    logic              ovf_q;
    logic              zero_q;
    logic              out_valid_q;

    logic              accept;
    logic              is_mul;
    logic [WIDTH-1:0]  sum_d;
    logic [WIDTH-1:0]  diff_d;
    logic [W2-1:0]     alu_res_d;
    logic              alu_ovf_d;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [W2-1:0]     acc_d;
    logic [W2-1:0]     prod_d;
    logic              prod_ovf_d;
    logic              mul_last;

    assign in_ready    = rst && (state_q == S_IDLE);
    assign accept      = in_valid && in_ready;
    assign is_mul      = (alu_control == 3'b110) && (MUL_EN != 0);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = (state_q == S_MUL);

    always_comb begin
        sum_d     = a + b;
        diff_d    = a - b;
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
        case (alu_control)
            3'b000: begin
                alu_res_d[MSB:0] = sum_d;
                alu_ovf_d = (a[MSB] == b[MSB]) && (sum_d[MSB] != a[MSB]);
            end
            3'b001: begin
                alu_res_d[MSB:0] = diff_d;
                alu_ovf_d = (a[MSB] != b[MSB]) && (diff_d[MSB] != a[MSB]);
            end
            3'b010:  alu_res_d[MSB:0] = b;
            3'b011:  alu_res_d = {a, b};
            3'b100:  alu_res_d[MSB:0] = a & b;
            default: alu_res_d[MSB:0] = a | b;
        endcase
    end

    // Multiply magnitudes unsigned and fix the sign at the end; |-2^(W-1)|
    // still fits in WIDTH unsigned bits, so the most negative pair is exact.
    assign a_mag      = a[MSB] ? (~a + WIDTH'(1)) : a;
    assign b_mag      = b[MSB] ? (~b + WIDTH'(1)) : b;
    assign acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_d     = neg_q ? (~acc_d + W2'(1)) : acc_d;
    assign prod_ovf_d = !((&prod_d[W2-1:MSB]) || !(|prod_d[W2-1:MSB]));
    assign mul_last   = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q  <= S_MUL;
                            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                            acc_q    <= '0;
                            neg_q    <= a[MSB] ^ b[MSB];
                            cnt_q    <= '0;
                        end else begin
                            result_q    <= alu_res_d;
                            ovf_q       <= alu_ovf_d;
                            zero_q      <= (alu_res_d[MSB:0] == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_last) begin
                        state_q     <= S_IDLE;
                        result_q    <= prod_d;
                        ovf_q       <= prod_ovf_d;
                        zero_q      <= (prod_d == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
